// File: rtl/dline_buffer.sv
// dline_buffer: single-line (32-byte) buffer between the load/store queue's
// word port and the 256-bit physical-memory line port. Holds one line with
// tag/valid/dirty; hits are answered from the line, misses write back the
// dirty line (if any) and then fill the requested one.
//
// Optional build macro: DLINE_WRITE_THROUGH_EN
//   defined   -> every store is also written through to pmem (state WT);
//                the line is never dirty.
//   undefined -> write-back behaviour.
module dline_buffer #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_tag    = 27
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [3:0]          mem_byte_enable,
    input  logic [31:0]         mem_address,
    input  logic [31:0]         mem_wdata,
    output logic                mem_resp,
    output logic [31:0]         mem_rdata,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [31:0]         pmem_address,
    output logic [s_line-1:0]   pmem_wdata,
    input  logic [s_line-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        RESP,
        WT
    } state_t;

    state_t             state;
    logic [s_line-1:0]  line;
    logic [s_tag-1:0]   tag;
    logic               valid;
    logic               dirty;
    logic [s_tag-1:0]   req_tag;

    // Address decode of the live request.
    logic [s_tag-1:0]      addr_tag;
    logic [s_offset-3:0]   word_idx;
    logic [s_offset+2:0]   bit_base;
    logic                  hit;
    logic                  is_req;
    logic                  is_write;
    logic                  unused_addr_bits;

    assign addr_tag         = mem_address[31:s_offset];
    assign word_idx         = mem_address[s_offset-1:2];
    assign bit_base         = {word_idx, 5'b0};
    assign hit              = valid && (tag == addr_tag);
    assign is_req           = mem_read || mem_write;
    assign is_write         = mem_write;          // read+write together counts as a write
    assign unused_addr_bits = &{1'b0, mem_address[1:0]};

    logic [31:0]        rd_word;
    logic [31:0]        new_word;
    logic [s_line-1:0]  merged_line;

    // Byte-lane merge of the store data into the addressed word of the line.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rd_word     = line[bit_base +: 32];
        new_word    = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                new_word[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
        merged_line = line;
        merged_line[bit_base +: 32] = new_word;
    end

    // Controller: state, line storage and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the line is a single register, not a RAM array, so it is cleared on reset like any other flop.
            state        <= IDLE;
            line         <= '0;
            tag          <= '0;
            valid        <= 1'b0;
            dirty        <= 1'b0;
            req_tag      <= '0;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            unique case (state)
                IDLE: begin
                    if (is_req) begin
                        if (hit) begin
                            if (is_write) begin
                                line <= merged_line;
`ifdef DLINE_WRITE_THROUGH_EN
                                pmem_write   <= 1'b1;
                                pmem_address <= {tag, {s_offset{1'b0}}};
                                pmem_wdata   <= merged_line;
                                state        <= WT;
`else
                                dirty    <= 1'b1;
                                mem_resp <= 1'b1;
                                state    <= RESP;
`endif
                            end else begin
                                mem_rdata <= rd_word;
                                mem_resp  <= 1'b1;
                                state     <= RESP;
                            end
                        end else begin
                            req_tag <= addr_tag;
                            if (valid && dirty) begin
                                pmem_write   <= 1'b1;
                                pmem_address <= {tag, {s_offset{1'b0}}};
                                pmem_wdata   <= line;
                                state        <= WB;
                            end else begin
                                pmem_read    <= 1'b1;
                                pmem_address <= {addr_tag, {s_offset{1'b0}}};
                                state        <= FILL;
                            end
                        end
                    end
                end
                WB: begin
                    if (pmem_resp) begin
                        dirty        <= 1'b0;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, {s_offset{1'b0}}};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        line      <= pmem_rdata;
                        valid     <= 1'b1;
                        tag       <= req_tag;
                        state     <= IDLE;
                    end
                end
                RESP: begin
                    mem_resp <= 1'b0;
                    state    <= IDLE;
                end
`ifdef DLINE_WRITE_THROUGH_EN
                WT: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        mem_resp   <= 1'b1;
                        state      <= RESP;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dline_buffer.sv
// tb_dline_buffer: directed vector table plus hand-written sequences for the
// flush-during-fill and reset-during-writeback corner cases. A small pmem
// model answers every line request after a fixed wait.
module tb_dline_buffer;

    localparam int MEM_LAT = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    dline_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // pmem model / protocol monitor state
    int           wait_cnt = 0;
    int           fill_count = 0;
    int           wb_count = 0;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    bit           mem_stall = 1'b0;
    bit           excl_viol = 1'b0;
    bit           stab_viol = 1'b0;
    logic         prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0]  prev_addr;
    logic [255:0] prev_wdata;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory image: word i of line L is L+i, except two known words at 0x1000.
    function automatic logic [255:0] fill_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[31:5], 2'b00, 3'(i)};
        if (a == 32'h0000_1000) begin
            l[1*32 +: 32] = 32'hDEAD_BEEF;
            l[2*32 +: 32] = 32'hAABB_CCDD;
        end
        return l;
    endfunction

    // Advance one clock, sample #1 after the edge, then run the pmem model.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (pmem_read && pmem_write) excl_viol = 1'b1;
        if (pmem_read && prev_rd && pmem_address !== prev_addr) stab_viol = 1'b1;
        if (pmem_write && prev_wr && (pmem_address !== prev_addr || pmem_wdata !== prev_wdata))
            stab_viol = 1'b1;
        pmem_resp = 1'b0;
        if (!(pmem_read || pmem_write)) begin
            wait_cnt = 0;
        end else if (!mem_stall) begin
            if (wait_cnt == MEM_LAT) begin
                pmem_resp = 1'b1;
                wait_cnt  = 0;
                if (pmem_read) begin
                    pmem_rdata = fill_line(pmem_address);
                    fill_count++;
                end else begin
                    wb_addr = pmem_address;
                    wb_data = pmem_wdata;
                    wb_count++;
                end
            end else begin
                wait_cnt++;
            end
        end
        // a response ends the held request, so the next cycle starts fresh
        prev_rd    = pmem_read && !pmem_resp;
        prev_wr    = pmem_write && !pmem_resp;
        prev_addr  = pmem_address;
        prev_wdata = pmem_wdata;
    endtask

    // Hold one request until mem_resp (bounded), then spend the RESP cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rdata, output int lat,
                             output int nf, output int nw, output logic [31:0] first_paddr);
        int f0 = fill_count;
        int w0 = wb_count;
        mem_read = rd; mem_write = wr; mem_byte_enable = be;
        mem_address = addr; mem_wdata = wd;
        lat = 0; rdata = '0; first_paddr = '0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (i == 1) first_paddr = pmem_address;
            if (mem_resp) begin
                lat   = i;
                rdata = mem_rdata;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        cycle();
        nf = fill_count - f0;
        nw = wb_count - w0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_fill;
        int          exp_wb;
        logic [31:0] exp_paddr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0]  rdata, fpa;
        logic [255:0] exp_wb_line;
        int           lat, nf, nw, f0;
        bit           saw_resp;
        bit           got;

        //              rd    wr    be     addr          wdata         rdata         lat f  w  first pmem addr
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 4, 1, 0, 32'h0000_1000};
        vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1, 0, 0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 4'h6, 32'h0000_1008, 32'h1122_3344, 32'h0,        1, 0, 0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000_1008, 32'h0,        32'hAA22_33DD, 1, 0, 0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 4'hF, 32'h0000_101C, 32'h1234_5678, 32'h0,        1, 0, 0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h0000_101C, 32'h0,        32'h1234_5678, 1, 0, 0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0,        32'h0000_2000, 6, 1, 1, 32'h0000_1000};
        vecs[7]  = '{1'b0, 1'b1, 4'h0, 32'h0000_2004, 32'hFFFF_FFFF, 32'h0,        1, 0, 0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h0000_2004, 32'h0,        32'h0000_2001, 1, 0, 0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 4'h9, 32'h0000_3010, 32'hA1B2_C3D4, 32'h0,        6, 1, 1, 32'h0000_2000};
        vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0000_3010, 32'h0,        32'hA100_30D4, 1, 0, 0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 4'hF, 32'h0000_3014, 32'hCAFE_F00D, 32'h0,        1, 0, 0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 4'h0, 32'h0000_3014, 32'h0,        32'hCAFE_F00D, 1, 0, 0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h0000_3017, 32'h0,        32'hCAFE_F00D, 1, 0, 0, 32'h0};

        exp_wb_line = {32'h1234_5678, 32'h0000_1006, 32'h0000_1005, 32'h0000_1004,
                       32'h0000_1003, 32'hAA22_33DD, 32'hDEAD_BEEF, 32'h0000_1000};

        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
        mem_address = '0; mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        wb_addr = '0; wb_data = '0; prev_addr = '0; prev_wdata = '0;
        cycle();
        cycle();
        check("rst_mem_resp",     mem_resp,     1'b0);
        check("rst_mem_rdata",    mem_rdata,    32'h0);
        check("rst_pmem_read",    pmem_read,    1'b0);
        check("rst_pmem_write",   pmem_write,   1'b0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata",   pmem_wdata,   256'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wd,
                      rdata, lat, nf, nw, fpa);
            check($sformatf("v%0d_latency", i), 256'(lat), 256'(vecs[i].exp_lat));
            check($sformatf("v%0d_fills", i),   256'(nf),  256'(vecs[i].exp_fill));
            check($sformatf("v%0d_wbs", i),     256'(nw),  256'(vecs[i].exp_wb));
            if (vecs[i].rd && !vecs[i].wr)
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_fill != 0)
                check($sformatf("v%0d_first_paddr", i), fpa, vecs[i].exp_paddr);
            if (i == 6) begin
                check("v6_wb_addr", wb_addr, 32'h0000_1000);
                check("v6_wb_line", wb_data, exp_wb_line);
            end
        end

        // Flush mid-miss: drop the read once the fill is underway.
        f0 = fill_count;
        saw_resp = 1'b0;
        got = 1'b0;
        mem_read = 1'b1; mem_address = 32'h0000_4008;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (mem_resp) saw_resp = 1'b1;
            if (pmem_read) got = 1'b1;
        end
        check("flush_fill_started", got, 1'b1);
        mem_read = 1'b0;
        for (int i = 0; i < 20 && fill_count == f0; i++) begin
            cycle();
            if (mem_resp) saw_resp = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (mem_resp) saw_resp = 1'b1;
        end
        check("flush_fills", 256'(fill_count - f0), 256'(1));
        check("flush_no_resp", saw_resp, 1'b0);
        do_access(1'b1, 1'b0, 4'h0, 32'h0000_4008, 32'h0, rdata, lat, nf, nw, fpa);
        check("flush_rehit_latency", 256'(lat), 256'(1));
        check("flush_rehit_rdata", rdata, 32'h0000_4002);

        // Reset during writeback: dirty the line, start a dirty miss, stall pmem.
        do_access(1'b0, 1'b1, 4'hF, 32'h0000_4000, 32'h5555_5555, rdata, lat, nf, nw, fpa);
        check("dirty_hit_latency", 256'(lat), 256'(1));
        mem_stall = 1'b1;
        mem_read = 1'b1; mem_address = 32'h0000_5000;
        cycle();
        check("wb_pmem_write", pmem_write, 1'b1);
        check("wb_pmem_address", pmem_address, 32'h0000_4000);
        #2 rst = 1'b1;
        #1;
        check("rst_wb_pmem_write", pmem_write, 1'b0);
        check("rst_wb_pmem_read", pmem_read, 1'b0);
        check("rst_wb_mem_resp", mem_resp, 1'b0);
        mem_read = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        mem_stall = 1'b0;
        do_access(1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0, rdata, lat, nf, nw, fpa);
        check("post_rst_latency", 256'(lat), 256'(4));
        check("post_rst_fills", 256'(nf), 256'(1));
        check("post_rst_wbs", 256'(nw), 256'(0));
        check("post_rst_rdata", rdata, 32'h0000_4000);

        check("pmem_rd_wr_exclusive", excl_viol, 1'b0);
        check("pmem_req_stable", stab_viol, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
